// File: rtl/timer_pkg.sv
// Shared constants, digit type and segment table for the MM:SS count-down timer.
package timer_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t TENS_MAX  = 4'd5;
  localparam digit_t UNITS_MAX = 4'd9;

  // Active-low segments, bit6 = a ... bit0 = g.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  function automatic digit_t clamp_digit(input digit_t d, input digit_t max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder; non-decimal codes blank the digit.
module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // NOTE: seg gets a default before the conditional so no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= UNITS_MAX) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/count_down_timer.sv
// MM:SS count-down timer with prescaled tick, sticky done and 7-segment outputs.
// Optional timed alarm output enabled by defining COUNT_DOWN_TIMER_ALARM_EN.
module count_down_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic [3:0] set_sec_1,
  input  logic [3:0] set_sec_2,
  input  logic [3:0] set_min_1,
  input  logic [3:0] set_min_2,
  output logic [6:0] sec_seg_1,
  output logic [6:0] sec_seg_2,
  output logic [6:0] min_seg_1,
  output logic [6:0] min_seg_2,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  digit_t sec_1, sec_2, min_1, min_2;
  logic [PRESC_W-1:0] presc;
  logic count_zero, last_sec, presc_wrap, presc_en, tick;
  logic [6:0] dec_sec_1, dec_sec_2, dec_min_1, dec_min_2;

  assign count_zero = ({min_2, min_1, sec_2, sec_1} == '0);
  assign last_sec   = ({min_2, min_1, sec_2} == '0) && (sec_1 == 4'd1);
  assign running    = rst && start && !count_zero;
  assign presc_wrap = (presc == PRESC_LAST);
  assign tick       = running && presc_wrap;

`ifdef COUNT_DOWN_TIMER_ALARM_EN
  localparam int ACNT_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  logic [ACNT_W-1:0] alarm_cnt;
  logic              alarm_q;

  // The prescaler keeps running after expiry so the alarm is measured in ticks.
  assign presc_en = running || alarm_q;
  assign alarm    = alarm_q;

  always_ff @(posedge clk) begin
    if (!rst || load) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (tick && last_sec) begin
      alarm_q   <= 1'b1;
      alarm_cnt <= '0;
    end else if (alarm_q && presc_wrap) begin
      if (alarm_cnt == ACNT_W'(ALARM_TICKS - 1)) alarm_q <= 1'b0;
      else                                       alarm_cnt <= alarm_cnt + 1'b1;
    end
  end
`else
  assign presc_en = running;
  assign alarm    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      {min_2, min_1, sec_2, sec_1} <= '0;
      presc <= '0;
      done  <= 1'b0;
    end else if (load) begin
      sec_1 <= clamp_digit(set_sec_1, UNITS_MAX);
      sec_2 <= clamp_digit(set_sec_2, TENS_MAX);
      min_1 <= clamp_digit(set_min_1, UNITS_MAX);
      min_2 <= clamp_digit(set_min_2, TENS_MAX);
      presc <= '0;
      done  <= 1'b0;
    end else if (presc_en) begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (tick) begin
        if (last_sec) done <= 1'b1;
        // Borrow chain; tick implies a nonzero count so min_2 never underflows.
        if (sec_1 != '0) begin
          sec_1 <= sec_1 - 1'b1;
        end else begin
          sec_1 <= UNITS_MAX;
          if (sec_2 != '0) begin
            sec_2 <= sec_2 - 1'b1;
          end else begin
            sec_2 <= TENS_MAX;
            if (min_1 != '0) begin
              min_1 <= min_1 - 1'b1;
            end else begin
              min_1 <= UNITS_MAX;
              min_2 <= min_2 - 1'b1;
            end
          end
        end
      end
    end
  end

  seg7_decode u_dec_sec_1 (.bcd(sec_1), .seg(dec_sec_1));
  seg7_decode u_dec_sec_2 (.bcd(sec_2), .seg(dec_sec_2));
  seg7_decode u_dec_min_1 (.bcd(min_1), .seg(dec_min_1));
  seg7_decode u_dec_min_2 (.bcd(min_2), .seg(dec_min_2));

  // Show "0" on every digit while reset is held, before the registers settle.
  assign sec_seg_1 = rst ? dec_sec_1 : SEG_TABLE[0];
  assign sec_seg_2 = rst ? dec_sec_2 : SEG_TABLE[0];
  assign min_seg_1 = rst ? dec_min_1 : SEG_TABLE[0];
  assign min_seg_2 = rst ? dec_min_2 : SEG_TABLE[0];

endmodule

// File: tb/tb_count_down_timer.sv
// Directed self-checking bench for count_down_timer with CLK_HZ=4, TICK_HZ=1 (DIV=4).
module tb_count_down_timer;

  logic       clk = 1'b0;
  logic       rst, load, start;
  logic [3:0] set_sec_1, set_sec_2, set_min_1, set_min_2;
  logic [6:0] sec_seg_1, sec_seg_2, min_seg_1, min_seg_2;
  logic       running, done, alarm;

  int n_checks = 0;
  int n_passed = 0;

  count_down_timer #(
    .CLK_HZ     (4),
    .TICK_HZ    (1),
    .ALARM_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .start    (start),
    .set_sec_1(set_sec_1),
    .set_sec_2(set_sec_2),
    .set_min_1(set_min_1),
    .set_min_2(set_min_2),
    .sec_seg_1(sec_seg_1),
    .sec_seg_2(sec_seg_2),
    .min_seg_1(min_seg_1),
    .min_seg_2(min_seg_2),
    .running  (running),
    .done     (done),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_disp(input string tag, input int m2, input int m1, input int s2, input int s1);
    check(tag, {4'h0, min_seg_2, min_seg_1, sec_seg_2, sec_seg_1},
               {4'h0, seg_of(m2), seg_of(m1), seg_of(s2), seg_of(s1)});
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int m2, input int m1, input int s2, input int s1);
    set_min_2 = 4'(m2);
    set_min_1 = 4'(m1);
    set_sec_2 = 4'(s2);
    set_sec_1 = 4'(s1);
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  logic alarm_on;

  initial begin
`ifdef COUNT_DOWN_TIMER_ALARM_EN
    alarm_on = 1'b1;
`else
    alarm_on = 1'b0;
`endif
    rst = 1'b0; load = 1'b0; start = 1'b0;
    set_sec_1 = '0; set_sec_2 = '0; set_min_1 = '0; set_min_2 = '0;

    // Reset state
    step(2);
    check_disp("reset_disp", 0, 0, 0, 0);
    check("reset_running", running, 0);
    check("reset_done", done, 0);
    check("reset_alarm", alarm, 0);
    rst = 1'b1;

    // Full expiry from 01:00, with a pause at 00:57 / prescaler 2
    start = 1'b1;
    do_load(0, 1, 0, 0);
    check_disp("load_0100", 0, 1, 0, 0);
    check("load_running", running, 1);
    step(4);
    check_disp("first_tick_0059", 0, 0, 5, 9);
    step(3);
    check_disp("hold_0059", 0, 0, 5, 9);
    step(1);
    check_disp("tick_0058", 0, 0, 5, 8);
    step(6);
    check_disp("at_0057", 0, 0, 5, 7);
    start = 1'b0;
    step(10);
    check_disp("pause_0057", 0, 0, 5, 7);
    check("pause_running", running, 0);
    start = 1'b1;
    step(1);
    check_disp("resume_1clk_0057", 0, 0, 5, 7);
    step(1);
    check_disp("resume_2clk_0056", 0, 0, 5, 6);
    step(223);
    check_disp("at_0001", 0, 0, 0, 1);
    check("pre_done", done, 0);
    check("pre_running", running, 1);
    check("pre_alarm", alarm, 0);
    step(1);
    check_disp("expiry_0000", 0, 0, 0, 0);
    check("expiry_done", done, 1);
    check("expiry_running", running, 0);
    check("alarm_start", alarm, alarm_on);
    step(7);
    check("alarm_clk8", alarm, alarm_on);
    step(1);
    check("alarm_end", alarm, 0);
    step(8);
    check_disp("hold_0000", 0, 0, 0, 0);
    check("hold_done", done, 1);

    // Load clears done and wins over a coincident tick
    do_load(0, 0, 0, 9);
    check("load_clears_done", done, 0);
    step(3);
    check_disp("pre_coincident", 0, 0, 0, 9);
    do_load(0, 0, 0, 5);
    check_disp("load_over_tick", 0, 0, 0, 5);
    check("load_over_tick_done", done, 0);
    step(3);
    check_disp("presc_cleared_hold", 0, 0, 0, 5);
    step(1);
    check_disp("presc_cleared_tick", 0, 0, 0, 4);

    // Borrow across minutes
    do_load(1, 0, 0, 0);
    step(4);
    check_disp("borrow_0959", 0, 9, 5, 9);
    step(4);
    check_disp("borrow_0958", 0, 9, 5, 8);

    // Clamping of illegal preset digits
    start = 1'b0;
    do_load(7, 7, 7, 7);
    check_disp("clamp_5757", 5, 7, 5, 7);
    do_load(9, 12, 6, 15);
    check_disp("clamp_5959", 5, 9, 5, 9);

    // Load of 00:00 never counts or signals done
    start = 1'b1;
    do_load(0, 0, 0, 0);
    step(20);
    check_disp("zero_load_disp", 0, 0, 0, 0);
    check("zero_load_running", running, 0);
    check("zero_load_done", done, 0);
    check("zero_load_alarm", alarm, 0);

    // Reset mid-count overrides a simultaneous load
    do_load(1, 0, 0, 0);
    step(6);
    check_disp("pre_reset_0959", 0, 9, 5, 9);
    rst = 1'b0;
    set_min_2 = 4'd3; set_min_1 = 4'd3; set_sec_2 = 4'd3; set_sec_1 = 4'd3;
    load = 1'b1;
    step(1);
    check_disp("in_reset_disp", 0, 0, 0, 0);
    check("in_reset_running", running, 0);
    check("in_reset_done", done, 0);
    rst = 1'b1;
    load = 1'b0;
    step(1);
    check_disp("post_reset_disp", 0, 0, 0, 0);
    step(5);
    check_disp("post_reset_idle", 0, 0, 0, 0);
    check("post_reset_running", running, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/count_down_timer.md
COUNT_DOWN_TIMER -- requirements
Module: count_down_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, meaning the countdown tick rate in Hz; DIV = CLK_HZ/TICK_HZ.
REQ-003 SHALL have parameter ALARM_TICKS, default 5, meaning the alarm duration in ticks.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port load, input, 1 bit: when high, captures the set_* digits.
REQ-007 SHALL have port start, input, 1 bit: level count-enable.
REQ-008 SHALL have ports set_sec_1, set_sec_2, set_min_1 and set_min_2, input, 4 bits each: BCD preset for seconds units, seconds tens, minutes units and minutes tens.
REQ-009 SHALL have ports sec_seg_1, sec_seg_2, min_seg_1 and min_seg_2, output, 7 bits each: active-low segments, bit6 = a through bit0 = g.
REQ-010 SHALL have port running, output, 1 bit: high when start=1 and the count is not 00:00.
REQ-011 SHALL have port done, output, 1 bit: sticky expiry flag.
REQ-012 SHALL have port alarm, output, 1 bit: the timed expiry indication.

Function
REQ-013 SHALL run a prescaler 0..DIV-1 only while running=1, issuing a one-clk tick when the prescaler equals DIV-1 and running=1; with start low, the prescaler and digits SHALL hold.
REQ-014 SHALL decrement MM:SS by one second on the tick edge, using borrow chains sec_1 9..0, sec_2 5..0, min_1 9..0 and min_2 5..0.
REQ-015 SHALL wrap borrows as follows: x0 seconds -> (x-1)9; 00 seconds with nonzero minutes -> 59 seconds and minutes minus one (example: 10:00 -> 09:59).
REQ-016 SHALL, on the tick that produces 00:00, set done on that same edge and stop counting; further ticks SHALL be suppressed.
REQ-017 SHALL, on load=1, capture the preset digits, clear the prescaler and clear done and alarm; load SHALL have priority over start and over a simultaneous tick.
REQ-018 SHALL clamp illegal preset digits on load: units >9 -> 9; tens >5 -> 5.
REQ-019 SHALL not count or assert done after a load of 00:00; done SHALL stay 0.
REQ-020 SHALL decode the segment outputs combinationally from the digit registers, so a display change is visible in the same cycle as the register update.

Reset
REQ-021 SHALL, when rst=0 at a clk edge, set: digits to 00:00; prescaler 0; done 0; alarm 0; alarm counter 0.
REQ-022 SHALL, while in reset, drive all four segment outputs to 7'b0000001 (the digit "0"), and running SHALL be 0.
REQ-023 SHALL treat reset asserted mid-count as overriding load, start and tick.

Configuration
REQ-024 SHALL use the macro COUNT_DOWN_TIMER_ALARM_EN.
REQ-025 SHALL, with COUNT_DOWN_TIMER_ALARM_EN defined, raise alarm on the edge done rises and hold it for ALARM_TICKS*DIV clocks; the prescaler free-runs for the alarm, and load or rst SHALL end the alarm early.
REQ-026 SHALL, without COUNT_DOWN_TIMER_ALARM_EN, keep the alarm port present but tie it to 0 and synthesise no alarm counter.

Structure
REQ-027 SHALL place digit width (4), tens maximum (5), units maximum (9) and the 10-entry active-low segment table in shared package timer_pkg.
REQ-028 SHALL implement one sub-module seg7_decode (4-bit BCD in, 7-bit active-low out; codes >9 -> all off, 7'b1111111), instantiated four times.

Verification (CLK_HZ=4, TICK_HZ=1, so DIV=4)
REQ-029 SHALL cover reset: rst=0 for 1 cycle mid-count -> digits 00:00, all segments 7'b0000001, done=0, running=0.
REQ-030 SHALL cover full expiry: load 01:00, start=1 -> 00:59 after 4 clocks; 00:00 after 240 clocks; done=1 and running=0 on that edge; count holds thereafter.
REQ-031 SHALL cover borrow: load 10:00, start=1 -> 09:59 after 4 clocks; then 09:58 after 4 more clocks.
REQ-032 SHALL cover pause: start=0 for 10 clocks at 00:57 with prescaler=2 -> digits and prescaler unchanged; resume -> 00:56 after 2 clocks.
REQ-033 SHALL cover load priority: load 00:05 coincident with a tick while running, done=0 -> 00:05, prescaler 0; load digits 7,7,7,7 (min_2,min_1,sec_2,sec_1) -> 57:57 shown.
REQ-034 SHALL cover the alarm: macro defined, ALARM_TICKS=2, expiry -> alarm=1 for exactly 8 clocks; macro undefined -> alarm=0 throughout.
